// File: rtl/ir_pkg.sv
// rtl/ir_pkg.sv - NEC decoder states, symbol timing windows (ticks) and window helper.
package ir_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD_MARK,
    S_LEAD_SPACE,
    S_BIT_MARK,
    S_BIT_SPACE,
    S_STOP_MARK
  } ir_state_e;

  localparam int LEAD_MARK_MIN  = 144;
  localparam int LEAD_MARK_MAX  = 176;
  localparam int LEAD_SPACE_MIN = 72;
  localparam int LEAD_SPACE_MAX = 88;
  localparam int REP_SPACE_MIN  = 36;
  localparam int REP_SPACE_MAX  = 44;
  localparam int BIT_MARK_MIN   = 7;
  localparam int BIT_MARK_MAX   = 13;
  localparam int ZERO_MIN       = 7;
  localparam int ZERO_MAX       = 13;
  localparam int ONE_MIN        = 25;
  localparam int ONE_MAX        = 35;
  localparam int NEC_DATA_BITS  = 32;

  function automatic logic in_win(input int w, input int lo, input int hi);
    return (w >= lo) && (w <= hi);
  endfunction

endpackage

// File: rtl/ir_tick_gen.sv
// rtl/ir_tick_gen.sv - Free-running prescaler emitting a one-clk tick every TICK_DIV clk.
module ir_tick_gen #(
  parameter int TICK_DIV = 2812
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [DW-1:0] div_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= '0;
      tick  <= 1'b0;
    end else if (div_q == DW'(TICK_DIV - 1)) begin
      div_q <= '0;
      tick  <= 1'b1;
    end else begin
      div_q <= div_q + DW'(1);
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/ir_nec_pulse_decoder.sv
// rtl/ir_nec_pulse_decoder.sv - NEC IR mark/space classifier driving a 33-bit shift register.
// Optional glitch filter on the synchronised input: IR_GLITCH_FILTER_EN.
module ir_nec_pulse_decoder
  import ir_pkg::*;
#(
  parameter int TICK_DIV = 2812,
  parameter int CNT_W    = 8,
  parameter int TIMEOUT  = 200
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ir_in,
  output logic shift,
  output logic serial_out,
  output logic en,
  output logic frame_done,
  output logic repeat_det,
  output logic err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             tick;
  logic [1:0]       sync_q;
  logic             ir_s, lvl, lvl_q, fall, rise, timeout, viol;
  logic [CNT_W-1:0] width_q;
  int               w;
  ir_state_e        state_q, state_d;
  logic [5:0]       bit_cnt_q, bit_cnt_d;
  logic             rep_q, rep_d;
  logic             shift_d, serial_d, en_d, done_d, repdet_d, err_d;

  ir_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= 2'b11;
    else          sync_q <= {sync_q[0], ir_in};
  end
  assign ir_s = sync_q[1];

`ifdef IR_GLITCH_FILTER_EN
  logic       flt_q;
  logic [2:0] hold_q;

  // Level flips only once the new value has been seen on 4 consecutive ticks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flt_q  <= 1'b1;
      hold_q <= '0;
    end else if (ir_s == flt_q) begin
      hold_q <= '0;
    end else if (tick) begin
      if (hold_q == 3'd3) begin
        flt_q  <= ir_s;
        hold_q <= '0;
      end else begin
        hold_q <= hold_q + 3'd1;
      end
    end
  end
  assign lvl = flt_q;
`else
  assign lvl = ir_s;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lvl_q <= 1'b1;
    else          lvl_q <= lvl;
  end
  assign fall = lvl_q & ~lvl;
  assign rise = ~lvl_q & lvl;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          width_q <= '0;
    else if (fall || rise)                 width_q <= '0;
    else if (tick && (width_q != CNT_MAX)) width_q <= width_q + CNT_W'(1);
  end

  assign w       = int'(width_q);
  assign timeout = (state_q != S_IDLE) && (w >= TIMEOUT);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rep_d     = rep_q;
    en_d      = en;
    shift_d   = 1'b0;
    serial_d  = 1'b0;
    done_d    = 1'b0;
    repdet_d  = 1'b0;
    err_d     = 1'b0;
    viol      = 1'b0;
    if (timeout) begin
      viol = 1'b1;
    end else begin
      case (state_q)
        S_IDLE:       if (fall) state_d = S_LEAD_MARK;
        S_LEAD_MARK:
          if (rise) begin
            if (in_win(w, LEAD_MARK_MIN, LEAD_MARK_MAX)) state_d = S_LEAD_SPACE;
            else viol = 1'b1;
          end
        S_LEAD_SPACE:
          if (fall) begin
            if (in_win(w, LEAD_SPACE_MIN, LEAD_SPACE_MAX)) begin
              en_d      = 1'b1;
              shift_d   = 1'b1;
              serial_d  = 1'b1;
              bit_cnt_d = '0;
              rep_d     = 1'b0;
              state_d   = S_BIT_MARK;
            end else if (in_win(w, REP_SPACE_MIN, REP_SPACE_MAX)) begin
              repdet_d = 1'b1;
              rep_d    = 1'b1;
              state_d  = S_STOP_MARK;
            end else begin
              viol = 1'b1;
            end
          end
        S_BIT_MARK:
          if (rise) begin
            if (in_win(w, BIT_MARK_MIN, BIT_MARK_MAX)) state_d = S_BIT_SPACE;
            else viol = 1'b1;
          end
        S_BIT_SPACE:
          if (fall) begin
            if (in_win(w, ZERO_MIN, ZERO_MAX) || in_win(w, ONE_MIN, ONE_MAX)) begin
              shift_d   = 1'b1;
              serial_d  = in_win(w, ONE_MIN, ONE_MAX);
              bit_cnt_d = bit_cnt_q + 6'd1;
              state_d   = (bit_cnt_q == 6'(NEC_DATA_BITS - 1)) ? S_STOP_MARK : S_BIT_MARK;
            end else begin
              viol = 1'b1;
            end
          end
        S_STOP_MARK:
          if (rise) begin
            if (in_win(w, BIT_MARK_MIN, BIT_MARK_MAX)) begin
              done_d  = ~rep_q;
              en_d    = 1'b0;
              state_d = S_IDLE;
            end else begin
              viol = 1'b1;
            end
          end
        default: state_d = S_IDLE;
      endcase
    end
    // A violation overrides anything decided above, including a same-cycle falling edge.
    if (viol) begin
      shift_d  = 1'b0;
      serial_d = 1'b0;
      done_d   = 1'b0;
      repdet_d = 1'b0;
      err_d    = 1'b1;
      en_d     = 1'b0;
      state_d  = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      rep_q      <= 1'b0;
      shift      <= 1'b0;
      serial_out <= 1'b0;
      en         <= 1'b0;
      frame_done <= 1'b0;
      repeat_det <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rep_q      <= rep_d;
      shift      <= shift_d;
      serial_out <= serial_d;
      en         <= en_d;
      frame_done <= done_d;
      repeat_det <= repdet_d;
      err        <= err_d;
    end
  end

endmodule

// File: tb/tb_ir_nec_pulse_decoder.sv
// tb/tb_ir_nec_pulse_decoder.sv - Scoreboard bench: NEC waveforms in, expected pulse stream compared by a monitor.
module tb_ir_nec_pulse_decoder;

  localparam int TD = 4;
  localparam int EV_SHIFT = 0, EV_DONE = 1, EV_REP = 2, EV_ERR = 3;

  typedef struct {
    int   kind;
    logic b;
  } ev_t;

  logic clk, reset_n, ir_in;
  logic shift, serial_out, en, frame_done, repeat_det, err;

  ev_t exp_q[$];
  int  checks, failures;
  int  npulse, kind;
  ev_t e;

  ir_nec_pulse_decoder #(.TICK_DIV(TD), .CNT_W(8), .TIMEOUT(200)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ir_in      (ir_in),
    .shift      (shift),
    .serial_out (serial_out),
    .en         (en),
    .frame_done (frame_done),
    .repeat_det (repeat_det),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push(input int k, input logic b);
    ev_t x;
    x.kind = k;
    x.b    = b;
    exp_q.push_back(x);
  endtask

  // Monitor: every output pulse must match the next expected event.
  always @(negedge clk) begin
    if (reset_n) begin
      npulse = int'(shift) + int'(frame_done) + int'(repeat_det) + int'(err);
      if (npulse > 1) begin
        checks++;
        failures++;
        $display("FAIL exclusive pulses=%0d required=1", npulse);
      end else if (npulse == 1) begin
        kind = shift ? EV_SHIFT : frame_done ? EV_DONE : repeat_det ? EV_REP : EV_ERR;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pulse kind=%0d required=none", kind);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_kind", kind, e.kind);
          if (kind == EV_SHIFT) chk("serial_out", serial_out, e.b);
          chk("en_at_pulse", en, (kind == EV_SHIFT) ? 1 : 0);
        end
      end
    end
  end

  task automatic drive(input logic lv, input int ticks);
    ir_in = lv;
    repeat (ticks * TD) @(negedge clk);
  endtask

  task automatic leader();
    drive(1'b0, $urandom_range(176, 145));
    push(EV_SHIFT, 1'b1);
    drive(1'b1, $urandom_range(88, 73));
  endtask

  task automatic data_bit(input logic b);
    drive(1'b0, $urandom_range(13, 8));
    push(EV_SHIFT, b);
    drive(1'b1, b ? $urandom_range(35, 26) : $urandom_range(13, 8));
  endtask

  task automatic stop_sym(input logic done);
    if (done) push(EV_DONE, 1'b0);
    drive(1'b0, $urandom_range(13, 8));
    drive(1'b1, 20);
  endtask

  task automatic full_frame(input logic [31:0] d);
    leader();
    for (int i = 31; i >= 0; i--) data_bit(d[i]);
    stop_sym(1'b1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired pending=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    ir_in    = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset_outputs", {26'd0, shift, serial_out, en, frame_done, repeat_det, err}, 0);
    reset_n = 1'b1;
    drive(1'b1, 20);

    full_frame(32'h00FF45BA);
    for (int k = 0; k < 2; k++) full_frame($urandom);

    // Repeat code
    drive(1'b0, 160);
    push(EV_REP, 1'b0);
    drive(1'b1, 40);
    stop_sym(1'b0);

    // Short leader mark
    drive(1'b0, 100);
    push(EV_ERR, 1'b0);
    drive(1'b1, 30);

    // Bad space on data bit 17
    leader();
    for (int i = 0; i < 16; i++) data_bit(1'($urandom_range(1, 0)));
    drive(1'b0, 10);
    push(EV_ERR, 1'b0);
    drive(1'b1, 20);
    drive(1'b0, 10);
    drive(1'b1, 40);

    // Stuck low after bit 5, then recovery
    leader();
    for (int i = 0; i < 5; i++) data_bit(1'($urandom_range(1, 0)));
    push(EV_ERR, 1'b0);
    drive(1'b0, 215);
    drive(1'b1, 30);
    full_frame($urandom);

    // Reset mid-frame at bit 12
    leader();
    for (int i = 0; i < 12; i++) data_bit(1'($urandom_range(1, 0)));
    drive(1'b0, 5);
    reset_n = 1'b0;
    #1;
    chk("midframe_reset_outputs", {26'd0, shift, serial_out, en, frame_done, repeat_det, err}, 0);
    chk("queue_before_reset", exp_q.size(), 0);
    ir_in = 1'b1;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    drive(1'b1, 20);
    full_frame($urandom);

`ifdef IR_GLITCH_FILTER_EN
    drive(1'b0, 80);
    drive(1'b1, 2);
    drive(1'b0, 78);
    push(EV_SHIFT, 1'b1);
    drive(1'b1, 80);
    for (int i = 31; i >= 0; i--) data_bit(1'(i % 3 == 0));
    stop_sym(1'b1);
`endif

    drive(1'b1, 40);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ir_nec_pulse_decoder.md
Name: ir_nec_pulse_decoder

Overview:
- Front-end stage of the IR reader. It samples the raw demodulated IR receiver output on the system clock and measures mark and space widths in prescaled ticks.
- It classifies NEC leader, bit and stop symbols.
- It drives the downstream 33-bit shift register with a shift strobe, a serial bit and an enable: one start-marker bit (1) followed by 32 data bits, MSB-first as received.
- Repeat codes and malformed frames are flagged separately.

Parameters:
- TICK_DIV, 2812: clk cycles per tick (50 MHz / 2812 ≈ 56.25 us, 1/10 of the 562.5 us NEC unit).
- CNT_W, 8: width of the saturating mark/space tick counter.
- TIMEOUT, 200: ticks of unchanged level that abort a frame.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- ir_in  in  1  raw receiver output, idle high, mark = low; asynchronous
- shift  out  1  one-clk strobe; serial_out valid in the same cycle
- serial_out  out  1  bit being shifted
- en  out  1  high from accepted leader until frame end or abort
- frame_done  out  1  one-clk pulse after a valid stop mark
- repeat_det  out  1  one-clk pulse on a valid NEC repeat code
- err  out  1  one-clk pulse on any timing violation or timeout

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters 0, synchroniser flops 1.
- Synchronisation: ir_in passes through 2 flops. Edge detection is on the synchronised signal, so latency from pin to edge is 2–3 clk.
- Tick generation: a free-running prescaler produces a 1-clk tick every TICK_DIV clk.
- Width counter:
  - Clears on every synchronised edge.
  - Increments on tick and saturates at 2^CNT_W-1.
  - The width classified at an edge is the count value before the clear.
- Timing windows (ticks, inclusive):
  - Leader mark 144–176.
  - Leader space 72–88 → frame; 36–44 → repeat.
  - Bit or stop mark 7–13.
  - Bit space 7–13 → 0; 25–35 → 1.
- FSM states: IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK.
- IDLE → LEAD_MARK on falling edge.
- LEAD_MARK → LEAD_SPACE on rising edge with the width in the leader window. Any other width: err, then IDLE.
- LEAD_SPACE on falling edge:
  - Frame window: en=1, shift pulse with serial_out=1 (start marker), bit counter=0, → BIT_MARK.
  - Repeat window: repeat_det pulse, → STOP_MARK with the repeat flag set.
  - Otherwise: err, → IDLE.
- BIT_MARK → BIT_SPACE on rising edge with the width in the mark window. Otherwise err.
- BIT_SPACE on falling edge:
  - Width in 0/1 window: shift pulse with serial_out = bit value, bit counter+1.
  - After the 32nd bit → STOP_MARK; else → BIT_MARK.
  - Out of window: err.
- STOP_MARK on rising edge with the width in the mark window:
  - If not a repeat: frame_done pulse.
  - en=0 in the same cycle, → IDLE.
- Timeout: in any non-IDLE state, counter reaching TIMEOUT → err pulse, en=0, → IDLE. This includes a stuck-low input.
- Every err path forces en=0 in the same cycle as the err pulse and returns to IDLE. A falling edge in that same cycle is ignored.
- Exactly 33 shift pulses per valid frame, never more. shift, frame_done, repeat_det and err are mutually exclusive in any cycle.
- Reset_n assertion mid-frame: immediate return to reset values. No pulse is emitted on release.

Optional Feature:
- IR_GLITCH_FILTER_EN defined: a filter sits after the synchroniser. The filtered level changes only after the synchronised input has held the new level for 4 consecutive ticks. Edges therefore lag by 4 ticks and pulses under 4 ticks are discarded. The windows apply unchanged.
- Not defined: the synchronised signal feeds edge detection directly.

Decomposition:
- Package ir_pkg: FSM state enum; window constants (LEAD_MARK_MIN/MAX, LEAD_SPACE_MIN/MAX, REP_SPACE_MIN/MAX, BIT_MARK_MIN/MAX, ZERO_MIN/MAX, ONE_MIN/MAX); NEC_DATA_BITS=32.
- Sub-module ir_tick_gen: TICK_DIV prescaler with async active-low reset and a 1-clk tick output.

Test Plan (TICK_DIV=4 for sim):
- Valid frame 0x00FF45BA (160/80 leader, 10/10 or 10/30 bits, 10-tick stop) → 33 shift pulses with serial_out sequence 1,0,0,0,0,0,0,0,0,1,…,0; en high throughout; frame_done once; err never.
- Repeat code (160 mark, 40 space, 10 stop) → repeat_det once; 0 shifts; en stays 0; frame_done 0.
- Leader mark 100 ticks → err pulse at rising edge; no shift; FSM IDLE.
- Bit-17 space of 20 ticks → 17 shifts, then err; en falls in the same cycle.
- Input stuck low after bit 5 → err after 200 ticks; en=0; the next valid frame decodes normally.
- reset_n pulsed low mid-frame at bit 12 → all outputs 0 immediately; the following full frame yields exactly 33 shifts. With IR_GLITCH_FILTER_EN, a 2-tick high glitch inside the leader mark is ignored and the frame decodes.
